// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory access sequencer: mux selector codes,
// grant owners, exception codes, data address sources and FSM states.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    SEL_PC  = 3'b000,
    SEL_ALU = 3'b001,
    SEL_A   = 3'b010,
    SEL_B   = 3'b011,
    SEL_253 = 3'b100,
    SEL_254 = 3'b101,
    SEL_255 = 3'b110
  } mem_sel_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_FETCH = 2'b01,
    GNT_DATA  = 2'b10,
    GNT_EXC   = 2'b11
  } grant_e;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'b00,
    EXC_BAD_OP = 2'b01,
    EXC_OVF    = 2'b10,
    EXC_DIV0   = 2'b11
  } exc_code_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_A    = 2'b01,
    SRC_B    = 2'b10,
    SRC_RSVD = 2'b11
  } data_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // The reserved source code falls back to ALUout.
  function automatic mem_sel_e data_sel(input logic [1:0] src);
    unique case (data_src_e'(src))
      SRC_A:   return SEL_A;
      SRC_B:   return SEL_B;
      default: return SEL_ALU;
    endcase
  endfunction

  function automatic mem_sel_e exc_sel(input logic [1:0] code);
    unique case (exc_code_e'(code))
      EXC_BAD_OP: return SEL_253;
      EXC_OVF:    return SEL_254;
      default:    return SEL_255;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_seq.sv
// Memory port sequencer: arbitrates fetch / data / exception-vector requests,
// owns the address-mux selector and write strobe, and pulses done on completion.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic [1:0] data_src,
  input  logic       data_we,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] mem_sel,
  output logic       mem_wr,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       epc_wr,
  output logic       exc_pc_load
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_e     state_q, state_d;
  mem_sel_e   mem_sel_q, mem_sel_d;
  grant_e     grant_q, grant_d;
  logic       mem_wr_q, mem_wr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       epc_wr_q, epc_wr_d;
  logic       exc_pc_load_q, exc_pc_load_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    mem_sel_d     = mem_sel_q;
    grant_d       = grant_q;
    mem_wr_d      = mem_wr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    epc_wr_d      = 1'b0;
    exc_pc_load_d = 1'b0;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        mem_sel_d  = SEL_PC;
        grant_d    = GNT_NONE;
        mem_wr_d   = 1'b0;
        busy_d     = 1'b0;
        wait_cnt_d = '0;
        // Fixed priority; an exception with code 00 is invisible to arbitration.
        if (exc_req && (exc_code != EXC_NONE)) begin
          grant_d    = GNT_EXC;
          mem_sel_d  = exc_sel(exc_code);
          epc_wr_d   = 1'b1;
          wait_cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (data_req) begin
          grant_d    = GNT_DATA;
          mem_sel_d  = data_sel(data_src);
          mem_wr_d   = data_we;
          wait_cnt_d = data_we ? CNT_W'(1) : CNT_W'(WAIT_CYCLES);
        end else if (fetch_req) begin
          grant_d    = GNT_FETCH;
          mem_sel_d  = SEL_PC;
          wait_cnt_d = CNT_W'(WAIT_CYCLES);
        end
        if (grant_d != GNT_NONE) begin
          state_d = ST_ACCESS;
          busy_d  = 1'b1;
        end
      end

      ST_ACCESS: begin
        if (wait_cnt_q <= CNT_W'(1)) begin
          state_d       = ST_DONE;
          mem_wr_d      = 1'b0;
          done_d        = 1'b1;
          exc_pc_load_d = (grant_q == GNT_EXC);
          wait_cnt_d    = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        mem_sel_d = SEL_PC;
        grant_d   = GNT_NONE;
        mem_wr_d  = 1'b0;
        busy_d    = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_sel_d = SEL_PC;
        grant_d   = GNT_NONE;
        mem_wr_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_sel_q     <= SEL_PC;
      grant_q       <= GNT_NONE;
      mem_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      epc_wr_q      <= 1'b0;
      exc_pc_load_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_sel_q     <= mem_sel_d;
      grant_q       <= grant_d;
      mem_wr_q      <= mem_wr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      epc_wr_q      <= epc_wr_d;
      exc_pc_load_q <= exc_pc_load_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign mem_sel     = mem_sel_q;
  assign mem_wr      = mem_wr_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign epc_wr      = epc_wr_q;
  assign exc_pc_load = exc_pc_load_q;

  a_wr_only_in_access: assert property (@(posedge clk) disable iff (reset)
    mem_wr_q |-> (state_q == ST_ACCESS));

  a_done_single_cycle: assert property (@(posedge clk) disable iff (reset)
    done_q |=> !done_q);

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Sequencer that owns the selector of the memory-address multiplexer and the memory write strobe. It arbitrates the single memory port between three requesters: instruction fetch, data load/store and exception-vector read. It inserts the memory read-latency wait states and returns a one-cycle completion pulse. It sits between the main control unit and the memory-address mux / memory, and replaces ad-hoc selector driving in the control FSM.

## Interface
- WAIT_CYCLES, 2, memory read latency in cycles (≥1); ACCESS length for reads.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  level request: read at PC.
- data_req  in  1  level request: data access.
- data_src  in  2  data address source: 00 ALUout, 01 reg A, 10 reg B, 11 reserved (treated as ALUout).
- data_we  in  1  1 = store, 0 = load; sampled with data_req.
- exc_req  in  1  level request: exception-vector read.
- exc_code  in  2  01 bad opcode (addr 253), 10 overflow (254), 11 divide-by-zero (255); 00 = exc_req ignored.
- mem_sel  out  3  mux selector: 000 PC, 001 ALUout, 010 A, 011 B, 100 253, 101 254, 110 255.
- mem_wr  out  1  memory write enable.
- grant  out  2  current owner: 00 none, 01 fetch, 10 data, 11 exception.
- busy  out  1  high in ACCESS and DONE.
- done  out  1  one-cycle completion pulse (read data valid this cycle for reads).
- epc_wr  out  1  one-cycle pulse: capture PC into EPC.
- exc_pc_load  out  1  one-cycle pulse with exception done: load PC from memory byte.

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: mem_sel=000, grant=00, mem_wr=0. Arbitrate with fixed priority exception > data > fetch. The winner's request, data_src, data_we and exc_code are latched and the state moves to ACCESS.
- Entering ACCESS: mem_sel is driven from the latched source and held constant for the whole of ACCESS and DONE. grant is set. wait_cnt is loaded.
- Exception grant: epc_wr pulses on the first ACCESS cycle only.
- Read (fetch, load, exception): ACCESS lasts exactly WAIT_CYCLES cycles, then the state moves to DONE.
- Store: ACCESS lasts exactly 1 cycle with mem_wr=1, then the state moves to DONE. mem_wr is never high outside that cycle.
- DONE: done=1 for one cycle. exc_pc_load=1 in the same cycle if grant=11. Requests are not sampled. The next state is always IDLE.
- Requests and their qualifiers changing during ACCESS or DONE are ignored. The latched values govern. Requesters hold their request until they see done.
- exc_req with exc_code=00 never wins. Lower-priority requests are arbitrated as if exc_req were low.
- data_src=11 behaves as 00 (mem_sel=001).
- Reset in any state: on the next edge go to IDLE, mem_sel=000, mem_wr=0, grant=00, busy=0, done=0, epc_wr=0, exc_pc_load=0, wait_cnt=0. No done is issued for an aborted access.

## Timing
- Request visible in IDLE cycle k: ACCESS begins at cycle k+1 and done is high in cycle k+1+WAIT_CYCLES (reads) or k+2 (stores).
- Minimum spacing between consecutive grants is 1 IDLE cycle. Throughput for back-to-back reads is one access per WAIT_CYCLES+2 cycles.
- wait_cnt width is $clog2(WAIT_CYCLES+1). It counts down to 1 and never wraps.
- Simultaneous requests in IDLE are resolved by priority only. There is no fairness or aging. A pending lower request is served in the next IDLE after the higher one completes.

## Structure
- Shared package mem_seq_pkg holds:
  - the 3-bit mem_sel codes (SEL_PC … SEL_255);
  - the grant encodings;
  - the exc_code encodings;
  - the state enum.
- The mux module itself is unchanged and instantiated by the top level, not inside this block.
- No sub-module is needed. The wait counter is inline.

## Test plan
- Reset, then fetch_req=1 with WAIT_CYCLES=2 → mem_sel=000 and grant=01 from cycle 1; done in cycle 3; busy in cycles 1–3; mem_wr=0 throughout.
- data_req=1, data_src=10, data_we=1 → mem_sel=011, mem_wr=1 for exactly one cycle; done the next cycle.
- exc_req=1 (exc_code=10), data_req=1 and fetch_req=1 together → exception wins: mem_sel=101, epc_wr pulses in the first ACCESS cycle, done and exc_pc_load together in the DONE cycle. Data is served next, fetch last.
- exc_req=1 with exc_code=00 and fetch_req=1 → fetch granted (grant=01); no epc_wr.
- data_src changed from 00 to 01 mid-ACCESS → mem_sel stays 001 until IDLE.
- reset asserted in the second ACCESS cycle of a read → next cycle all outputs at reset values; no done pulse; a new request is served normally afterwards.
